id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register placed directly downstream of the register file read ports.
- Captures operands, immediate, register indices and the control bundle each cycle for EX.
- Applies a WB-to-ID bypass, because the register file writes on the clock edge but reads combinationally, so a same-cycle write is not yet visible at its read ports.
- Detects load-use hazards, raises a one-cycle stall to IF/ID and the PC, inserts a bubble on flush, and keeps saturating stall and flush performance counters.

---
 rtl/id_ex_stage_if.sv | 46 ++++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: ID and WB inputs, EX outputs, hazard and perf status.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_readdata1;
  logic [DATA_W-1:0] id_readdata2;
  logic [DATA_W-1:0] id_imm;
  logic [7:0]        id_ctrl;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_write_data;
  logic              flush;
  logic              stall;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_readdata1;
  logic [DATA_W-1:0] ex_readdata2;
  logic [DATA_W-1:0] ex_imm;
  logic [7:0]        ex_ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  // Upstream/control side: presents the ID instruction and WB write, observes EX state
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_readdata1, id_readdata2, id_imm, id_ctrl,
    output wb_reg_write, wb_rd, wb_write_data, flush,
    input  stall, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_readdata1, ex_readdata2, ex_imm,
    input  ex_ctrl, stall_count, flush_count
  );

  // Pipeline register side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_readdata1, id_readdata2, id_imm, id_ctrl,
    input  wb_reg_write, wb_rd, wb_write_data, flush,
    output stall, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_readdata1, ex_readdata2, ex_imm,
    output ex_ctrl, stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB-to-ID bypass, load-use stall detection,
// flush bubbles and saturating stall/flush counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);
  localparam int unsigned MemReadBit = 6;

  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_rdata1_q, ex_rdata1_d;
  logic [DATA_W-1:0] ex_rdata2_q, ex_rdata2_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [7:0]        ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              stall;
  logic [DATA_W-1:0] op1, op2;

  // Load-use hazard: EX load targets a register the ID instruction reads; flush overrides
  always_comb begin
    stall = bus.id_valid && ex_valid_q && ex_ctrl_q[MemReadBit] && (ex_rd_q != '0) &&
            ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2)) && !bus.flush;
  end

  // WB-to-ID bypass: register file write is not yet visible at its read ports; x0 never bypassed
  always_comb begin
    op1 = bus.id_readdata1;
    op2 = bus.id_readdata2;
    if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1)) begin
      op1 = bus.wb_write_data;
    end
    if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2)) begin
      op2 = bus.wb_write_data;
    end
  end

  // Next EX state: bubble on flush or stall, otherwise capture the ID instruction
  always_comb begin
    ex_valid_d  = 1'b0;
    ex_rs1_d    = '0;
    ex_rs2_d    = '0;
    ex_rd_d     = '0;
    ex_rdata1_d = '0;
    ex_rdata2_d = '0;
    ex_imm_d    = '0;
    ex_ctrl_d   = '0;
    if (!bus.flush && !stall) begin
      ex_valid_d  = bus.id_valid;
      ex_rs1_d    = bus.id_rs1;
      ex_rs2_d    = bus.id_rs2;
      ex_rd_d     = bus.id_rd;
      ex_rdata1_d = op1;
      ex_rdata2_d = op2;
      ex_imm_d    = bus.id_imm;
      ex_ctrl_d   = bus.id_valid ? bus.id_ctrl : 8'h00;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      ex_rdata1_q <= ex_rdata1_d;
      ex_rdata2_q <= ex_rdata2_d;
      ex_imm_q    <= ex_imm_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_rs1       = ex_rs1_q;
  assign bus.ex_rs2       = ex_rs2_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_readdata1 = ex_rdata1_q;
  assign bus.ex_readdata2 = ex_rdata2_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; narrow counters so saturation is reachable.
module tb_id_ex_stage;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [CW-1:0] exp_stall;
  logic [CW-1:0] exp_flush;

  id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are then driven/sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid      = 1'b0;
    bus.id_rs1        = '0;
    bus.id_rs2        = '0;
    bus.id_rd         = '0;
    bus.id_readdata1  = '0;
    bus.id_readdata2  = '0;
    bus.id_imm        = '0;
    bus.id_ctrl       = '0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_write_data = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic present(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [7:0] ctrl);
    bus.id_valid     = 1'b1;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rd        = rd;
    bus.id_ctrl      = ctrl;
    bus.id_readdata1 = 64'h11;
    bus.id_readdata2 = 64'h22;
    bus.id_imm       = 64'h33;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.id_valid      = 1'b1;
      bus.id_rs1        = AW'($urandom);
      bus.id_rs2        = AW'($urandom);
      bus.id_rd         = AW'($urandom);
      bus.id_readdata1  = {$urandom, $urandom};
      bus.id_readdata2  = {$urandom, $urandom};
      bus.id_imm        = {$urandom, $urandom};
      bus.id_ctrl       = 8'hff;
      bus.wb_reg_write  = 1'b1;
      bus.wb_rd         = AW'($urandom);
      bus.wb_write_data = {$urandom, $urandom};
      bus.flush         = 1'($urandom);
      tick();
    end
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_ex_valid got %0h want 0", bus.ex_valid); end
    n_checks++; if (bus.ex_readdata1 !== '0 || bus.ex_readdata2 !== '0 || bus.ex_imm !== '0) begin
      n_fail++; $display("FAIL reset_data got %0h/%0h/%0h want 0", bus.ex_readdata1,
                         bus.ex_readdata2, bus.ex_imm); end
    n_checks++; if (bus.ex_ctrl !== 8'h00 || bus.ex_rd !== '0 || bus.ex_rs1 !== '0 ||
                    bus.ex_rs2 !== '0) begin n_fail++;
      $display("FAIL reset_ctrl_idx got ctrl %0h rd %0h want 0", bus.ex_ctrl, bus.ex_rd); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++;
      $display("FAIL reset_stall got %0h want 0", bus.stall); end
    n_checks++; if (bus.stall_count !== '0 || bus.flush_count !== '0) begin n_fail++;
      $display("FAIL reset_counters got %0h/%0h want 0/0", bus.stall_count, bus.flush_count); end
    idle_inputs();
    reset = 1'b1;
    bus.id_valid     = 1'b1;
    bus.id_rs1       = 5'd5;
    bus.id_readdata1 = 64'd72;
    tick();
    n_checks++; if (bus.ex_readdata1 !== 64'd72 || bus.ex_valid !== 1'b1) begin n_fail++;
      $display("FAIL first_capture got %0d v%0b want 72 v1", bus.ex_readdata1, bus.ex_valid); end
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_bypass();
    idle_inputs();
    bus.id_valid      = 1'b1;
    bus.id_rs1        = 5'd3;
    bus.id_rs2        = 5'd4;
    bus.id_readdata1  = 64'd3522;
    bus.id_readdata2  = 64'd11;
    bus.wb_reg_write  = 1'b1;
    bus.wb_rd         = 5'd3;
    bus.wb_write_data = 64'd99;
    tick();
    n_checks++; if (bus.ex_readdata1 !== 64'd99 || bus.ex_readdata2 !== 64'd11) begin n_fail++;
      $display("FAIL bypass_op1 got %0d/%0d want 99/11", bus.ex_readdata1, bus.ex_readdata2); end
    bus.wb_rd         = 5'd4;
    bus.wb_write_data = 64'd55;
    tick();
    n_checks++; if (bus.ex_readdata1 !== 64'd3522 || bus.ex_readdata2 !== 64'd55) begin n_fail++;
      $display("FAIL bypass_op2 got %0d/%0d want 3522/55", bus.ex_readdata1, bus.ex_readdata2); end
    bus.wb_reg_write = 1'b0;
    tick();
    n_checks++; if (bus.ex_readdata2 !== 64'd11) begin n_fail++;
      $display("FAIL bypass_no_write got %0d want 11", bus.ex_readdata2); end
    bus.wb_reg_write  = 1'b1;
    bus.wb_rd         = 5'd0;
    bus.id_rs1        = 5'd0;
    bus.id_readdata1  = 64'd0;
    bus.wb_write_data = 64'd99;
    tick();
    n_checks++; if (bus.ex_readdata1 !== 64'd0) begin n_fail++;
      $display("FAIL bypass_x0 got %0d want 0", bus.ex_readdata1); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    present(5'd1, 5'd2, 5'd7, 8'hc0);
    tick();
    n_checks++; if (bus.ex_ctrl !== 8'hc0 || bus.ex_rd !== 5'd7) begin n_fail++;
      $display("FAIL load_capture got ctrl %0h rd %0d want c0 7", bus.ex_ctrl, bus.ex_rd); end
    present(5'd8, 5'd7, 5'd9, 8'h80);
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++;
      $display("FAIL load_use_stall got %0b want 1", bus.stall); end
    exp_stall = exp_stall + 1'b1;
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL load_use_bubble got v%0b ctrl %0h stall %0b want v0 0 0",
                         bus.ex_valid, bus.ex_ctrl, bus.stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9 || bus.ex_ctrl !== 8'h80) begin
      n_fail++; $display("FAIL load_use_resume got v%0b rd %0d ctrl %0h want v1 9 80",
                         bus.ex_valid, bus.ex_rd, bus.ex_ctrl); end
    n_checks++; if (bus.stall_count !== exp_stall) begin n_fail++;
      $display("FAIL load_use_count got %0d want %0d", bus.stall_count, exp_stall); end
  endtask

  task automatic test_load_x0();
    present(5'd1, 5'd2, 5'd0, 8'hc0);
    tick();
    present(5'd0, 5'd3, 5'd4, 8'h80);
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++;
      $display("FAIL load_x0_stall got %0b want 0", bus.stall); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd4) begin n_fail++;
      $display("FAIL load_x0_capture got v%0b rd %0d want v1 4", bus.ex_valid, bus.ex_rd); end
  endtask

  task automatic test_flush_hazard();
    present(5'd1, 5'd2, 5'd7, 8'hc0);
    tick();
    present(5'd7, 5'd2, 5'd9, 8'h80);
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++;
      $display("FAIL flush_stall got %0b want 0", bus.stall); end
    exp_flush = exp_flush + 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 || bus.ex_rd !== '0) begin
      n_fail++; $display("FAIL flush_bubble got v%0b ctrl %0h rd %0d want 0", bus.ex_valid,
                         bus.ex_ctrl, bus.ex_rd); end
    n_checks++; if (bus.flush_count !== exp_flush || bus.stall_count !== exp_stall) begin
      n_fail++; $display("FAIL flush_count got %0d/%0d want %0d/%0d", bus.flush_count,
                         bus.stall_count, exp_flush, exp_stall); end
  endtask

  task automatic test_bypass_during_stall();
    present(5'd1, 5'd2, 5'd7, 8'hc0);
    bus.wb_reg_write = 1'b0;
    tick();
    present(5'd7, 5'd3, 5'd9, 8'h80);
    bus.wb_reg_write  = 1'b1;
    bus.wb_rd         = 5'd3;
    bus.wb_write_data = 64'haaaa;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++;
      $display("FAIL bds_stall got %0b want 1", bus.stall); end
    exp_stall = exp_stall + 1'b1;
    tick();
    n_checks++; if (bus.ex_readdata2 !== '0 || bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL bds_bubble got %0h v%0b want 0 v0", bus.ex_readdata2, bus.ex_valid); end
    bus.wb_write_data = 64'hbbbb;
    tick();
    bus.wb_reg_write = 1'b0;
    n_checks++; if (bus.ex_readdata2 !== 64'hbbbb || bus.ex_readdata1 !== 64'h11) begin
      n_fail++; $display("FAIL bds_rebypass got %0h/%0h want bbbb/11", bus.ex_readdata2,
                         bus.ex_readdata1); end
  endtask

  task automatic one_stall();
    present(5'd1, 5'd2, 5'd7, 8'hc0);
    tick();
    present(5'd7, 5'd2, 5'd9, 8'h80);
    tick();
    if (exp_stall != '1) exp_stall = exp_stall + 1'b1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40 && exp_stall != 4'd14; i++) one_stall();
    n_checks++; if (bus.stall_count !== 4'd14) begin n_fail++;
      $display("FAIL sat_pre got %0d want 14", bus.stall_count); end
    one_stall();
    n_checks++; if (bus.stall_count !== 4'd15) begin n_fail++;
      $display("FAIL sat_max got %0d want 15", bus.stall_count); end
    one_stall();
    n_checks++; if (bus.stall_count !== 4'd15) begin n_fail++;
      $display("FAIL sat_hold got %0d want 15", bus.stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    present(5'd1, 5'd2, 5'd7, 8'hc0);
    tick();
    present(5'd7, 5'd2, 5'd9, 8'h80);
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++;
      $display("FAIL mid_stall_pre got %0b want 1", bus.stall); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0 || bus.ex_valid !== 1'b0 || bus.stall_count !== '0) begin
      n_fail++; $display("FAIL mid_stall_reset got stall %0b v%0b cnt %0d want 0 0 0",
                         bus.stall, bus.ex_valid, bus.stall_count); end
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_load_use();
    test_load_x0();
    test_flush_hazard();
    test_bypass_during_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
